pc_seq_ctrl: RTL

- Program-counter sequencer for the single-cycle CPU with jump support.
- Owns the PC register and drives the instruction-fetch handshake.
- Selects the next PC from four sources: sequential, taken branch, J/JAL pseudo-direct jump, and JR register jump.
- Handles pipeline stall and flush/trap redirect. It builds the jump target internally as {PC+4[31:28], instr_index, 2'b00}.

---
 rtl/pc_seq_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pc_seq_ctrl.sv
// Program-counter sequencer: owns the PC, drives the fetch handshake and picks the next PC.
// Optional macro JR_ALIGN_CHECK_EN traps misaligned JR targets to TRAP_PC and adds misalign_o.
module pc_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0080
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        fetch_valid_o,
    input  logic        fetch_ready_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    input  logic        stall_i,
    input  logic        ctrl_valid_i,
    input  logic        jump_i,
    input  logic [25:0] instr_index_i,
    input  logic        branch_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_offset_i,
    input  logic        jr_i,
    input  logic [31:0] jr_target_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic        redirect_o
`ifdef JR_ALIGN_CHECK_EN
    ,
    output logic        misalign_o
`endif
);

    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

`ifdef JR_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_redirect;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_jump_target;
    logic [31:0] w_branch_target;
    logic        w_jr_misaligned;
    logic [31:0] w_jr_target;
    logic        w_commit;
    logic [31:0] w_next_pc;
    logic        w_nonseq;

    assign w_pc_plus4      = r_pc + 32'd4;
    assign w_jump_target   = {w_pc_plus4[31:28], instr_index_i, 2'b00};
    assign w_branch_target = w_pc_plus4 + {branch_offset_i[29:0], 2'b00};
    assign w_jr_misaligned = ALIGN_CHECK && (jr_target_i[1:0] != 2'b00);
    assign w_jr_target     = w_jr_misaligned ? TRAP_PC : jr_target_i;
    assign w_commit        = (r_state == RUN) && fetch_ready_i && !stall_i;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_next_pc = w_pc_plus4;
        w_nonseq  = 1'b0;
        if (ctrl_valid_i && jr_i) begin
            w_next_pc = w_jr_target;
            w_nonseq  = 1'b1;
        end else if (ctrl_valid_i && jump_i) begin
            w_next_pc = w_jump_target;
            w_nonseq  = 1'b1;
        end else if (ctrl_valid_i && branch_i && branch_taken_i) begin
            w_next_pc = w_branch_target;
            w_nonseq  = 1'b1;
        end
    end

`ifdef JR_ALIGN_CHECK_EN
    logic r_misalign;
`endif

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= BOOT;
            r_pc       <= RESET_PC;
            r_redirect <= 1'b0;
`ifdef JR_ALIGN_CHECK_EN
            r_misalign <= 1'b0;
`endif
        end else begin
            r_redirect <= 1'b0;
`ifdef JR_ALIGN_CHECK_EN
            r_misalign <= 1'b0;
`endif
            if (flush_i) begin
                // Flush overrides stall and any commit, from every state.
                r_pc       <= flush_pc_i;
                r_state    <= RUN;
                r_redirect <= 1'b1;
            end else begin
                case (r_state)
                    BOOT: r_state <= RUN;
                    RUN: begin
                        if (stall_i) begin
                            r_state <= HOLD;
                        end else if (w_commit) begin
                            r_pc       <= w_next_pc;
                            r_redirect <= w_nonseq;
`ifdef JR_ALIGN_CHECK_EN
                            r_misalign <= ctrl_valid_i && jr_i && w_jr_misaligned;
`endif
                        end
                    end
                    HOLD: begin
                        if (!stall_i) r_state <= RUN;
                    end
                    default: r_state <= BOOT;
                endcase
            end
        end
    end

    // Fetch request drops in the same cycle a stall is raised.
    assign fetch_valid_o = (r_state == RUN) && !stall_i;
    assign pc_o          = r_pc;
    assign pc_plus4_o    = w_pc_plus4;
    assign redirect_o    = r_redirect;
`ifdef JR_ALIGN_CHECK_EN
    assign misalign_o    = r_misalign;
`endif

endmodule
